dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the CPU's load/store port. It accepts one request at a time over a req/ack handshake and inserts a configurable number of wait states. It performs byte, halfword or word accesses on an internal word-organised RAM and returns sign- or zero-extended read data. It sits between the CPU's execute/memory stage (ALU result as address, rs2 as write data) and the data RAM, and replaces the zero-latency direct RAM hookup.

## Interface
- DEPTH_LOG2, 12: log2 of RAM depth in 32-bit words (16 KiB at default).
- WAIT_CYCLES, 1: wait states between acceptance and response. Range 0..15.
- clk_i  input  1  cpu clock; all state changes on rising edge.
- reset_i  input  1  reset, asynchronous, active-high.
- req_i  input  1  request valid; initiator holds it and all request fields stable until ack_o.
- we_i  input  1  1 = store, 0 = load.
- adr_i  input  32  byte address.
- wd_i  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- size_i  input  2  00 byte, 01 half, 10 word, 11 reserved.
- unsigned_i  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- ack_o  output  1  one-cycle response strobe.
- err_o  output  1  valid with ack_o; 1 = access rejected.
- rd_o  output  32  load data, valid with ack_o; holds its value otherwise.

## Operation
- Requests are accepted one at a time and move through IDLE, WAIT and RESP.
- **IDLE.** On a rising edge with req_i=1, the block latches we/adr/wd/size/unsigned and checks the request.
  - The request is bad if any of these hold: size_i=11; half with adr[0]=1; word with adr[1:0]≠00; any of adr[31:DEPTH_LOG2+2] set.
  - Bad request: set err flag and go to RESP. No RAM access; rd_o is unchanged.
  - Good request with WAIT_CYCLES=0: perform the access on this edge and go to RESP.
  - Good request otherwise: load cnt=WAIT_CYCLES-1 and go to WAIT.
- **WAIT.** While cnt≠0, decrement cnt. When cnt=0, perform the access on this edge and go to RESP.
- **RESP.** ack_o=1 (err_o = latched flag) for exactly one cycle, then return to IDLE.
  - req_i is ignored in RESP.
  - If req_i is still high in the following IDLE cycle, it is treated as a new request.
- **Access.** Word index is adr[DEPTH_LOG2+1:2].
- **Stores** write only the addressed lanes; other bytes of the word are preserved.
  - Byte: lane adr[1:0] gets wd[7:0].
  - Half: lanes {adr[1],0} and {adr[1],1} get wd[15:0].
  - Word: all four lanes get wd.
  - rd_o is not updated by a store.
- **Loads** select the lane(s) by adr[1:0], then extend to 32 bits per unsigned_i. Word loads ignore unsigned_i.
- **RAM.** Synchronous write, read sampled at the access edge. Contents are not cleared by reset.

## Timing
- Reset values: state=IDLE, cnt=0, ack_o=0, err_o=0, rd_o=0.
- Reset asserted mid-transaction aborts it: no ack is issued.
  - A write whose access edge has not occurred is not performed.
  - A completed write is retained.
- Latency, good request: acceptance edge E → ack_o high in the cycle after edge E+WAIT_CYCLES. That is WAIT_CYCLES+1 cycles after acceptance.
- Latency, bad request: ack_o in the cycle after E regardless of WAIT_CYCLES.
- Throughput: at most one request per WAIT_CYCLES+2 cycles, because one IDLE cycle is needed between transactions.
- Initiator behaviour with changing fields while req_i=1 and before ack is outside the contract. The block uses the latched copy.

## Test plan
- Word store/load, WAIT_CYCLES=1.
  - Store 0xDEADBEEF to 0x10 → ack 2 cycles after acceptance, err=0.
  - Load 0x10 → rd_o=0xDEADBEEF.
- Byte/half lanes and extension.
  - After word 0xDEADBEEF at 0x10, store byte 0x80 to 0x11 → word reads 0xDEAD80EF.
  - Signed byte load 0x11 → 0xFFFFFF80; unsigned → 0x00000080.
  - Signed half load 0x12 → 0xFFFFDEAD.
- Errors.
  - Word load at 0x13 → err=1 and ack 1 cycle after acceptance.
  - size=11 → err=1.
  - Address 0x0001_0000 with DEPTH_LOG2=12 → err=1 on a store, and RAM is unchanged (verify by reloading).
- WAIT_CYCLES=0 and WAIT_CYCLES=3.
  - Ack 1 and 4 cycles after acceptance respectively.
  - req_i held high continuously → new acceptance every 2 and 5 cycles.
- Reset mid-WAIT during a store of 0x12345678 to 0x20 (prior 0x0) → no ack; outputs go to 0 asynchronously. After release, load 0x20 → 0x00000000.
- rd_o hold: after a load returning 0xA5A5A5A5, a subsequent store and a bad request leave rd_o=0xA5A5A5A5.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Load/store request bus between the CPU memory stage and dmem_responder.
// The initiator drives the request fields; the responder returns ack/err/read data.
interface dmem_responder_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] adr_i;
    logic [31:0] wd_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic        ack_o;
    logic        err_o;
    logic [31:0] rd_o;

    modport master (
        output req_i, we_i, adr_i, wd_i, size_i, unsigned_i,
        input  ack_o, err_o, rd_o
    );

    modport slave (
        input  req_i, we_i, adr_i, wd_i, size_i, unsigned_i,
        output ack_o, err_o, rd_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time over req/ack, with WAIT_CYCLES
// wait states in front of a word-organised RAM supporting byte/half/word lanes.
module dmem_responder #(
    parameter int DEPTH_LOG2  = 12,
    parameter int WAIT_CYCLES = 1
) (
    input  logic            clk_i,
    input  logic            reset_i,
    dmem_responder_if.slave bus
);
    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam int         AW        = DEPTH_LOG2 + 2;
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic        unsigned_q;
    logic        err_q;
    logic [AW-1:0] adr_q;
    logic [31:0] wd_q;
    logic [1:0]  size_q;
    logic [31:0] rd_q;
    logic [31:0] mem [DEPTH];

    logic          reqBad;
    logic          accept;
    logic          doAccess;
    logic          accWe;
    logic          accUns;
    logic [AW-1:0] accAdr;
    logic [31:0]   accWd;
    logic [1:0]    accSize;
    logic [DEPTH_LOG2-1:0] wordIdx;
    logic [3:0]    laneEn;
    logic [31:0]   laneData;
    logic [31:0]   rdWord;
    logic [31:0]   rdShift;
    logic [31:0]   rdExt;

    always_comb begin
        reqBad = 1'b0;
        case (bus.size_i)
            2'b01:   reqBad = bus.adr_i[0];
            2'b10:   reqBad = |bus.adr_i[1:0];
            2'b11:   reqBad = 1'b1;
            default: reqBad = 1'b0;
        endcase
        if (|bus.adr_i[31:AW]) begin
            reqBad = 1'b1;
        end
    end

    assign accept = (state_q == IDLE) && bus.req_i;

    // With zero wait states the access happens on the acceptance edge, so it must
    // use the live bus fields instead of the copies latched on that same edge.
    always_comb begin
        if (state_q == IDLE) begin
            accWe   = bus.we_i;
            accUns  = bus.unsigned_i;
            accAdr  = bus.adr_i[AW-1:0];
            accWd   = bus.wd_i;
            accSize = bus.size_i;
        end else begin
            accWe   = we_q;
            accUns  = unsigned_q;
            accAdr  = adr_q;
            accWd   = wd_q;
            accSize = size_q;
        end
    end

    assign doAccess = !reset_i &&
                      ((accept && !reqBad && (WAIT_CYCLES == 0)) ||
                       ((state_q == WAIT) && (cnt_q == 4'd0)));

    assign wordIdx = accAdr[AW-1:2];
    assign rdWord  = mem[wordIdx];
    assign rdShift = rdWord >> {accAdr[1:0], 3'b000};

    always_comb begin
        laneEn   = 4'b1111;
        laneData = accWd;
        rdExt    = rdWord;
        case (accSize)
            2'b00: begin
                laneEn   = 4'b0001 << accAdr[1:0];
                laneData = {4{accWd[7:0]}};
                rdExt    = {{24{rdShift[7] & ~accUns}}, rdShift[7:0]};
            end
            2'b01: begin
                laneEn   = accAdr[1] ? 4'b1100 : 4'b0011;
                laneData = {2{accWd[15:0]}};
                rdExt    = {{16{rdShift[15] & ~accUns}}, rdShift[15:0]};
            end
            default: begin
                laneEn   = 4'b1111;
                laneData = accWd;
                rdExt    = rdWord;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (doAccess && accWe) begin
            for (int l = 0; l < 4; l++) begin
                if (laneEn[l]) begin
                    mem[wordIdx][8*l +: 8] <= laneData[8*l +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.req_i) begin
                    if (reqBad || (WAIT_CYCLES == 0)) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            we_q       <= 1'b0;
            unsigned_q <= 1'b0;
            err_q      <= 1'b0;
            adr_q      <= '0;
            wd_q       <= '0;
            size_q     <= 2'b00;
            rd_q       <= '0;
        end else begin
            if (accept) begin
                we_q       <= bus.we_i;
                unsigned_q <= bus.unsigned_i;
                err_q      <= reqBad;
                adr_q      <= bus.adr_i[AW-1:0];
                wd_q       <= bus.wd_i;
                size_q     <= bus.size_i;
            end
            if (doAccess && !accWe) begin
                rd_q <= rdExt;
            end
        end
    end

    always_comb begin
        bus.ack_o = (state_q == RESP);
        bus.err_o = (state_q == RESP) && err_q;
        bus.rd_o  = rd_q;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT_CYCLES 0, 1, 3) checked against a
// byte-addressed reference memory with randomized and directed load/store traffic.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reqA  [3];
    logic        weA   [3];
    logic [31:0] adrA  [3];
    logic [31:0] wdA   [3];
    logic [1:0]  sizeA [3];
    logic        unsA  [3];
    logic [2:0]  ackV;
    logic [2:0]  errV;
    logic [31:0] rdA   [3];

    int errors = 0;
    int checks = 0;

    logic [7:0]  memModel [int];
    logic [31:0] rdModel  [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gDut
        localparam int WC = (g == 0) ? 0 : (g == 1) ? 1 : 3;
        dmem_responder_if bus ();
        assign bus.req_i      = reqA[g];
        assign bus.we_i       = weA[g];
        assign bus.adr_i      = adrA[g];
        assign bus.wd_i       = wdA[g];
        assign bus.size_i     = sizeA[g];
        assign bus.unsigned_i = unsA[g];
        assign ackV[g]        = bus.ack_o;
        assign errV[g]        = bus.err_o;
        assign rdA[g]         = bus.rd_o;
        dmem_responder #(.DEPTH_LOG2(12), .WAIT_CYCLES(WC)) dut (
            .clk_i   (clk),
            .reset_i (rst),
            .bus     (bus)
        );
    end

    function automatic int waitOf(input int d);
        return (d == 0) ? 0 : (d == 1) ? 1 : 3;
    endfunction

    function automatic bit isBad(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'b11) || (a >= 32'h4000) ||
               (sz == 2'b01 && (a % 2) != 0) || (sz == 2'b10 && (a % 4) != 0);
    endfunction

    function automatic int expLat(input int d, input logic [31:0] a, input logic [1:0] sz);
        return isBad(a, sz) ? 1 : waitOf(d) + 1;
    endfunction

    function automatic logic [31:0] modelLoad(input int d, input logic [31:0] a,
                                              input logic [1:0] sz, input logic u);
        int n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        logic [31:0] v = 32'h0;
        for (int i = 0; i < n; i++) begin
            v = v | (32'(memModel[d * 65536 + int'(a) + i]) << (8 * i));
        end
        if (!u && n < 4 && v[8*n-1]) begin
            v = v | (32'hFFFF_FFFF << (8 * n));
        end
        return v;
    endfunction

    task automatic modelStore(input int d, input logic [31:0] a, input logic [31:0] wdat,
                              input logic [1:0] sz);
        int n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        for (int i = 0; i < n; i++) begin
            memModel[d * 65536 + int'(a) + i] = wdat[8*i +: 8];
        end
    endtask

    // Called at a negedge with the DUT idle; returns ack latency (-1 on timeout).
    task automatic applyStimulus(input int d, input logic w, input logic [31:0] a,
                                 input logic [31:0] wdat, input logic [1:0] sz, input logic u,
                                 output logic gotErr, output logic [31:0] gotRd, output int lat);
        weA[d] = w; adrA[d] = a; wdA[d] = wdat; sizeA[d] = sz; unsA[d] = u;
        reqA[d] = 1'b1;
        @(posedge clk);
        lat = -1; gotErr = 1'bx; gotRd = 32'hx;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (ackV[d] === 1'b1) begin
                lat = c; gotErr = errV[d]; gotRd = rdA[d];
                break;
            end
        end
        reqA[d] = 1'b0;
        @(negedge clk);
        if (!w && !isBad(a, sz)) rdModel[d] = modelLoad(d, a, sz, u);
        if (w && !isBad(a, sz)) modelStore(d, a, wdat, sz);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({ackV[d], errV[d], rdA[d]} !== 34'h0) begin
                errors++;
                $display("[TB] FAIL reset_outputs[%0d]: got ack=%b err=%b rd=%h expected 0/0/0",
                         d, ackV[d], errV[d], rdA[d]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_word_store_load();
        logic e; logic [31:0] r; int lat;
        applyStimulus(1, 1'b1, 32'h10, 32'hDEAD_BEEF, 2'b10, 1'b0, e, r, lat);
        checks++;
        if (lat !== 2 || e !== 1'b0) begin
            errors++;
            $display("[TB] FAIL word_store: got lat=%0d err=%b expected lat=2 err=0", lat, e);
        end
        applyStimulus(1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, e, r, lat);
        checks++;
        if (lat !== 2 || e !== 1'b0 || r !== 32'hDEAD_BEEF) begin
            errors++;
            $display("[TB] FAIL word_load: got lat=%0d err=%b rd=%h expected 2/0/deadbeef", lat, e, r);
        end
    endtask

    task automatic test_lanes();
        logic e; logic [31:0] r; int lat;
        logic [31:0] adrT [4] = '{32'h10, 32'h11, 32'h11, 32'h12};
        logic [1:0]  szT  [4] = '{2'b10, 2'b00, 2'b00, 2'b01};
        logic        uT   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] expT [4] = '{32'hDEAD_80EF, 32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_DEAD};
        applyStimulus(1, 1'b1, 32'h11, 32'hFFFF_FF80, 2'b00, 1'b0, e, r, lat);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1'b0, adrT[i], 32'h0, szT[i], uT[i], e, r, lat);
            checks++;
            if (r !== expT[i] || e !== 1'b0) begin
                errors++;
                $display("[TB] FAIL lane_load[%0d]: got rd=%h err=%b expected rd=%h err=0",
                         i, r, e, expT[i]);
            end
        end
    endtask

    task automatic test_errors();
        logic e; logic [31:0] r; int lat; logic [31:0] held;
        held = rdModel[1];
        applyStimulus(1, 1'b0, 32'h13, 32'h0, 2'b10, 1'b0, e, r, lat);
        checks++;
        if (e !== 1'b1 || lat !== 1 || r !== held) begin
            errors++;
            $display("[TB] FAIL misaligned_word: got err=%b lat=%0d rd=%h expected 1/1/%h", e, lat, r, held);
        end
        applyStimulus(1, 1'b0, 32'h10, 32'h0, 2'b11, 1'b0, e, r, lat);
        checks++;
        if (e !== 1'b1) begin
            errors++;
            $display("[TB] FAIL size_reserved: got err=%b expected 1", e);
        end
        applyStimulus(1, 1'b1, 32'h0001_0010, 32'h1111_2222, 2'b10, 1'b0, e, r, lat);
        checks++;
        if (e !== 1'b1) begin
            errors++;
            $display("[TB] FAIL oob_store: got err=%b expected 1", e);
        end
        applyStimulus(1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, e, r, lat);
        checks++;
        if (r !== 32'hDEAD_80EF) begin
            errors++;
            $display("[TB] FAIL oob_ram_intact: got rd=%h expected dead80ef", r);
        end
        applyStimulus(2, 1'b0, 32'h12, 32'h0, 2'b11, 1'b0, e, r, lat);
        checks++;
        if (e !== 1'b1 || lat !== 1) begin
            errors++;
            $display("[TB] FAIL bad_lat_wait3: got err=%b lat=%0d expected 1/1", e, lat);
        end
    endtask

    task automatic test_latency();
        logic e; logic [31:0] r; int lat;
        logic [31:0] dat [3] = '{32'hCAFE_F00D, 32'h0, 32'h0BAD_C0DE};
        for (int d = 0; d < 3; d += 2) begin
            applyStimulus(d, 1'b1, 32'h10, dat[d], 2'b10, 1'b0, e, r, lat);
            checks++;
            if (lat !== waitOf(d) + 1 || e !== 1'b0) begin
                errors++;
                $display("[TB] FAIL store_lat[%0d]: got lat=%0d err=%b expected lat=%0d err=0",
                         d, lat, e, waitOf(d) + 1);
            end
            applyStimulus(d, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, e, r, lat);
            checks++;
            if (lat !== waitOf(d) + 1 || r !== dat[d]) begin
                errors++;
                $display("[TB] FAIL load_lat[%0d]: got lat=%0d rd=%h expected lat=%0d rd=%h",
                         d, lat, r, waitOf(d) + 1, dat[d]);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int d = 0; d < 3; d += 2) begin
            int ackCyc [4];
            int n = 0;
            weA[d] = 1'b0; adrA[d] = 32'h10; wdA[d] = 32'h0; sizeA[d] = 2'b10; unsA[d] = 1'b0;
            reqA[d] = 1'b1;
            for (int c = 1; c <= 60 && n < 4; c++) begin
                @(negedge clk);
                if (ackV[d] === 1'b1) begin
                    ackCyc[n] = c;
                    n++;
                end
            end
            reqA[d] = 1'b0;
            @(negedge clk);
            checks++;
            if (n != 4 || ackCyc[0] != waitOf(d) + 1) begin
                errors++;
                $display("[TB] FAIL b2b_first[%0d]: got acks=%0d first=%0d expected 4/%0d",
                         d, n, (n > 0) ? ackCyc[0] : -1, waitOf(d) + 1);
            end
            for (int k = 1; k < n; k++) begin
                checks++;
                if (ackCyc[k] - ackCyc[k-1] != waitOf(d) + 2) begin
                    errors++;
                    $display("[TB] FAIL b2b_spacing[%0d]: got %0d cycles expected %0d",
                             d, ackCyc[k] - ackCyc[k-1], waitOf(d) + 2);
                end
            end
            checks++;
            if (rdA[d] !== rdModel[d]) begin
                errors++;
                $display("[TB] FAIL b2b_rd[%0d]: got %h expected %h", d, rdA[d], rdModel[d]);
            end
        end
    endtask

    task automatic test_rd_hold();
        logic e; logic [31:0] r; int lat;
        applyStimulus(1, 1'b1, 32'h30, 32'hA5A5_A5A5, 2'b10, 1'b0, e, r, lat);
        applyStimulus(1, 1'b0, 32'h30, 32'h0, 2'b10, 1'b0, e, r, lat);
        applyStimulus(1, 1'b1, 32'h34, 32'h0000_1234, 2'b01, 1'b0, e, r, lat);
        checks++;
        if (rdA[1] !== 32'hA5A5_A5A5) begin
            errors++;
            $display("[TB] FAIL rd_hold_store: got %h expected a5a5a5a5", rdA[1]);
        end
        applyStimulus(1, 1'b0, 32'h31, 32'h0, 2'b01, 1'b0, e, r, lat);
        checks++;
        if (rdA[1] !== 32'hA5A5_A5A5 || e !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rd_hold_bad: got rd=%h err=%b expected a5a5a5a5/1", rdA[1], e);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic e; logic [31:0] r; int lat; bit sawAck;
        applyStimulus(2, 1'b1, 32'h20, 32'h0, 2'b10, 1'b0, e, r, lat);
        applyStimulus(2, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, e, r, lat);
        weA[2] = 1'b1; adrA[2] = 32'h20; wdA[2] = 32'h1234_5678; sizeA[2] = 2'b10;
        reqA[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (rdA[2] !== 32'h0 || ackV[2] !== 1'b0 || errV[2] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset_out: got rd=%h ack=%b err=%b expected 0/0/0",
                     rdA[2], ackV[2], errV[2]);
        end
        reqA[2] = 1'b0;
        sawAck = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ackV[2] === 1'b1) sawAck = 1'b1;
        end
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ackV[2] === 1'b1) sawAck = 1'b1;
        end
        checks++;
        if (sawAck) begin
            errors++;
            $display("[TB] FAIL abort_no_ack: got ack=1 expected none");
        end
        for (int d = 0; d < 3; d++) rdModel[d] = 32'h0;
        applyStimulus(2, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, e, r, lat);
        checks++;
        if (r !== 32'h0 || e !== 1'b0 || lat !== 4) begin
            errors++;
            $display("[TB] FAIL aborted_write: got rd=%h err=%b lat=%0d expected 0/0/4", r, e, lat);
        end
    endtask

    task automatic test_random();
        logic e; logic [31:0] r; int lat;
        for (int d = 0; d < 3; d++) begin
            for (int w = 0; w < 16; w++) begin
                applyStimulus(d, 1'b1, 32'(w * 4), $urandom, 2'b10, 1'b0, e, r, lat);
            end
            for (int i = 0; i < 40; i++) begin
                logic        w;
                logic [31:0] a;
                logic [1:0]  sz;
                logic        u;
                logic [31:0] wdat;
                bit          bad;
                int          expL;
                w = 1'($urandom_range(0, 1));
                a = 32'($urandom_range(0, 63));
                sz = 2'($urandom_range(0, 3));
                u = 1'($urandom_range(0, 1));
                wdat = $urandom;
                if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(14, 31));
                bad = isBad(a, sz);
                expL = expLat(d, a, sz);
                applyStimulus(d, w, a, wdat, sz, u, e, r, lat);
                checks++;
                if (e !== 1'(bad) || lat !== expL || r !== rdModel[d]) begin
                    errors++;
                    $display("[TB] FAIL random[%0d.%0d] we=%b a=%h sz=%0d u=%b: got err=%b lat=%0d rd=%h expected %b/%0d/%h",
                             d, i, w, a, sz, u, e, lat, r, bad, expL, rdModel[d]);
                end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            reqA[d] = 1'b0; weA[d] = 1'b0; adrA[d] = 32'h0; wdA[d] = 32'h0;
            sizeA[d] = 2'b00; unsA[d] = 1'b0; rdModel[d] = 32'h0;
        end
        test_reset();
        test_word_store_load();
        test_lanes();
        test_errors();
        test_latency();
        test_back_to_back();
        test_rd_hold();
        test_reset_mid_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
